// File: rtl/fetch_unit.sv
// PC register and instruction fetch FSM for the 16-bit multicycle datapath.
// Optional fetch watchdog is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int unsigned          WIDTH          = 16,
  parameter logic [WIDTH-1:0]     RESET_PC       = '0,
  parameter int unsigned          TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] next_pc,
  input  logic [WIDTH-1:0] rlink_in,
  input  logic             jal_en,
  input  logic             pc_update,
  input  logic             stall,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_rd_en,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic [WIDTH-1:0] rlink,
  output logic             fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] instr_q;
  logic             valid_q;
  logic [WIDTH-1:0] rlink_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic          err_q;
  logic [CW-1:0] cnt_q;

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      rlink_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
`ifdef FETCH_TIMEOUT_EN
          // WAIT is only reachable through REQ, so clearing here equals clearing on entry.
          cnt_q <= '0;
`endif
          if (mem_ready) begin
            instr_q <= mem_rdata;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            instr_q <= mem_rdata;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_q == LIMIT) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_REQ;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        S_HOLD: begin
          if (pc_update && !stall) begin
            pc_q    <= next_pc;
            valid_q <= 1'b0;
            state_q <= S_REQ;
            if (jal_en) begin
              rlink_q <= rlink_in;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc          = pc_q;
  assign mem_addr    = pc_q;
  assign mem_rd_en   = (state_q == S_REQ) || (state_q == S_WAIT);
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign rlink       = rlink_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, compared against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] next_pc, rlink_in, mem_rdata;
  logic             jal_en, pc_update, stall, mem_ready;
  logic [WIDTH-1:0] pc, mem_addr, instr, rlink;
  logic             mem_rd_en, instr_valid, fetch_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: a request is outstanding, or an instruction is held, or
  // the stage is idling just after reset.
  logic [WIDTH-1:0] m_pc, m_instr, m_rlink;
  logic             m_valid, m_err, m_pending, m_starting;
  int unsigned      m_unanswered;

  fetch_unit #(
    .WIDTH         (WIDTH),
    .RESET_PC      (16'h0000),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .next_pc    (next_pc),
    .rlink_in   (rlink_in),
    .jal_en     (jal_en),
    .pc_update  (pc_update),
    .stall      (stall),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pc         (pc),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .instr      (instr),
    .instr_valid(instr_valid),
    .rlink      (rlink),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = 16'h0000; m_instr = '0; m_valid = 1'b0; m_rlink = '0; m_err = 1'b0;
      m_pending = 1'b0; m_starting = 1'b1; m_unanswered = 0;
    end else begin
      m_err = 1'b0;
      if (m_starting) begin
        m_starting = 1'b0; m_pending = 1'b1; m_unanswered = 0;
      end else if (m_pending) begin
        if (mem_ready) begin
          m_instr = mem_rdata; m_valid = 1'b1; m_pending = 1'b0;
        end else begin
          m_unanswered++;
`ifdef FETCH_TIMEOUT_EN
          // one REQ cycle plus TIMEOUT wait cycles without an answer
          if (m_unanswered == TIMEOUT + 1) begin
            m_err = 1'b1; m_unanswered = 0;
          end
`endif
        end
      end else if (pc_update && !stall) begin
        m_pc = next_pc; m_valid = 1'b0; m_pending = 1'b1; m_unanswered = 0;
        if (jal_en) m_rlink = rlink_in;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("pc",          pc,          m_pc);
    check_eq("mem_addr",    mem_addr,    m_pc);
    check_eq("mem_rd_en",   mem_rd_en,   m_pending);
    check_eq("instr_valid", instr_valid, m_valid);
    check_eq("instr",       instr,       m_instr);
    check_eq("rlink",       rlink,       m_rlink);
    check_eq("fetch_err",   fetch_err,   m_err);
  endtask

  task automatic step(input logic rst, input logic [15:0] npc, input logic [15:0] rl,
                      input logic jal, input logic upd, input logic stl,
                      input logic [15:0] rdata, input logic rdy);
    reset = rst; next_pc = npc; rlink_in = rl; jal_en = jal;
    pc_update = upd; stall = stl; mem_rdata = rdata; mem_ready = rdy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    // Reset and start-up: IDLE for one cycle, then the first request at 0
    step(1, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0);
    step(1, 16'h0, 16'h0, 0, 0, 0, 16'h0, 1);
    check_eq("reset_rd_en_low", mem_rd_en, 1'b0);
    step(0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0);
    check_eq("first_req", {mem_rd_en, mem_addr}, {1'b1, 16'h0000});

    // Zero-wait fetch then commit to 1
    step(0, 16'h0, 16'h0, 0, 0, 0, 16'h5A01, 1);
    check_eq("zero_wait_instr", {instr_valid, instr}, {1'b1, 16'h5A01});
    step(0, 16'h0001, 16'h0, 0, 1, 0, 16'h0, 0);
    check_eq("commit_pc1", {mem_rd_en, pc}, {1'b1, 16'h0001});

    // Three-cycle latency with ignored pc_update during the wait
    step(0, 16'h1234, 16'h0, 1, 1, 0, 16'hDEAD, 0);
    step(0, 16'h1234, 16'h0, 1, 1, 0, 16'hBEEF, 0);
    check_eq("wait_pc_stable", pc, 16'h0001);
    step(0, 16'h1234, 16'h0, 0, 0, 0, 16'h7C03, 1);
    check_eq("wait_instr", instr, 16'h7C03);

    // JAL commit, then a plain commit keeps rlink
    step(0, 16'h0200, 16'h0011, 1, 1, 0, 16'h0, 0);
    step(0, 16'h0, 16'h0, 0, 0, 0, 16'h1111, 1);
    step(0, 16'h0300, 16'hFFFF, 0, 1, 0, 16'h0, 0);
    check_eq("rlink_kept", rlink, 16'h0011);
    step(0, 16'h0, 16'h0, 0, 0, 0, 16'h2222, 1);

    // Stall holds off the commit for four cycles
    for (int i = 0; i < 4; i++) step(0, 16'h0400, 16'h0, 0, 1, 1, 16'h0, 0);
    check_eq("stall_pc", pc, 16'h0300);
    step(0, 16'hFFFF, 16'h0, 0, 1, 0, 16'h0, 0);
    check_eq("commit_ffff", {mem_rd_en, mem_addr}, {1'b1, 16'hFFFF});

    // Memory never answers: watchdog behaviour (or none) for 100 cycles
    for (int i = 0; i < 100; i++) step(0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0);
    step(0, 16'h0, 16'h0, 0, 0, 0, 16'h3333, 1);
    check_eq("ffff_fetched", {instr_valid, pc}, {1'b1, 16'hFFFF});

    // Random traffic with occasional mid-fetch resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) == 0),
           16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0), 16'($urandom),
           (($urandom_range(0, 30) == 0) ? 1'b0 : ($urandom_range(0, 2) == 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
